aes_key_expand_seq: RTL and testbench

Sequential AES-128 key-schedule unit that sits directly upstream of the aes_top round datapath and supplies its round keys.
- On a start pulse it latches the cipher key, then generates round keys 0..10 at one per clock.
- Each round key is streamed out with a valid strobe and index.
- All 11 round keys are held in an internal key store with a registered random-access read port, which the round datapath fetches from during encryption.

---
 rtl/aes_key_expand_seq_if.sv | 20 ++
 rtl/aes_key_expand_seq.sv | 95 +++++++++
 tb/tb_aes_key_expand_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_seq_if.sv
// aes_key_expand_seq_if: request, round-key stream and key-store read port of the AES-128 key expander
interface aes_key_expand_seq_if;
  logic         i_start;
  logic [127:0] i_key;
  logic         o_busy;
  logic         o_rk_valid;
  logic [3:0]   o_rk_idx;
  logic [127:0] o_round_key;
  logic         o_done;
  logic [3:0]   i_rd_idx;
  logic [127:0] o_rd_key;
  modport master (
    output i_start, i_key, i_rd_idx,
    input  o_busy, o_rk_valid, o_rk_idx, o_round_key, o_done, o_rd_key
  );
  modport slave (
    input  i_start, i_key, i_rd_idx,
    output o_busy, o_rk_valid, o_rk_idx, o_round_key, o_done, o_rd_key
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: sequential AES-128 key schedule, streams round keys 0..10 one per clock into a readable key store
module aes_key_expand_seq #(
  parameter bit STORE_KEYS = 1
) (
  input logic clk,
  input logic rst,
  aes_key_expand_seq_if.slave bus
);
  // FIPS-197 forward S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t       state;
  logic [3:0]   round;
  logic [127:0] key_reg;
  logic [31:0]  t, n0, n1, n2, n3;
  logic [127:0] nkey;
  function automatic logic [7:0] sub(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  assign t    = {sub(key_reg[23:16]), sub(key_reg[15:8]), sub(key_reg[7:0]), sub(key_reg[31:24])}
              ^ {RCON[round], 24'h0};
  assign n0   = key_reg[127:96] ^ t;
  assign n1   = key_reg[95:64] ^ n0;
  assign n2   = key_reg[63:32] ^ n1;
  assign n3   = key_reg[31:0] ^ n2;
  assign nkey = {n0, n1, n2, n3};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      round           <= '0;
      key_reg         <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_rk_valid  <= 1'b0;
      bus.o_rk_idx    <= '0;
      bus.o_round_key <= '0;
      bus.o_done      <= 1'b0;
    end else if (state == IDLE) begin
      bus.o_rk_valid <= bus.i_start;
      bus.o_busy     <= bus.i_start;
      bus.o_done     <= 1'b0;
      if (bus.i_start) begin
        key_reg         <= bus.i_key;
        bus.o_round_key <= bus.i_key;
        bus.o_rk_idx    <= '0;
        round           <= 4'd1;
        state           <= EXPAND;
      end
    end else begin
      key_reg         <= nkey;
      bus.o_round_key <= nkey;
      bus.o_rk_idx    <= round;
      bus.o_rk_valid  <= 1'b1;
      round           <= round + 4'd1;
      if (round == 4'd10) begin
        bus.o_done <= 1'b1;
        bus.o_busy <= 1'b0;
        state      <= IDLE;
      end
    end
  generate
    if (STORE_KEYS) begin : g_store
      logic [127:0] store [11];
      logic         we;
      logic [3:0]   wi;
      logic [127:0] wd;
      assign we = (state == EXPAND) || bus.i_start;
      assign wi = state == IDLE ? 4'd0 : round;
      assign wd = state == IDLE ? bus.i_key : nkey;
      // read sees the pre-write contents when indices collide
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          for (int i = 0; i < 11; i++) store[i] <= '0;
          bus.o_rd_key <= '0;
        end else begin
          if (we) store[wi] <= wd;
          bus.o_rd_key <= bus.i_rd_idx > 4'd10 ? '0 : store[bus.i_rd_idx];
        end
    end else begin : g_nostore
      assign bus.o_rd_key = '0;
    end
  endgenerate
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: directed vectors for the key expander, with and without the key store
module tb_aes_key_expand_seq;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1H1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K1HA = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2H1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2HA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk [11];
  aes_key_expand_seq_if bus ();
  aes_key_expand_seq_if bus0 ();
  assign bus0.i_start  = bus.i_start;
  assign bus0.i_key    = bus.i_key;
  assign bus0.i_rd_idx = bus.i_rd_idx;
  aes_key_expand_seq #(.STORE_KEYS(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  aes_key_expand_seq #(.STORE_KEYS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  // S-box derived from the GF(2^8) inverse and affine map, independent of any table
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  task automatic start_exp(input logic [127:0] k);
    bus.i_start = 1'b1;
    bus.i_key   = k;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_key   = ~k;
  endtask
  task automatic stream(input logic [127:0] k, input logic [127:0] h1, input logic [127:0] h10,
                        input int poke, input logic chain, input logic [127:0] nk);
    int dn = 0;
    logic go;
    expand(k);
    for (int i = 0; i <= 10; i++) begin
      chk("valid", 128'(bus.o_rk_valid), 128'(1));
      chk("idx", 128'(bus.o_rk_idx), 128'(i));
      chk("round_key", bus.o_round_key, rk[i]);
      chk("busy", 128'(bus.o_busy), 128'(i != 10));
      chk("done", 128'(bus.o_done), 128'(i == 10));
      chk("nostore_key", bus0.o_round_key, rk[i]);
      chk("nostore_valid", 128'(bus0.o_rk_valid), 128'(1));
      chk("nostore_rd", bus0.o_rd_key, 128'(0));
      if (i == 1) chk("hand_idx1", bus.o_round_key, h1);
      if (i == 10) chk("hand_idx10", bus.o_round_key, h10);
      dn += int'(bus.o_done);
      go = (i == poke) || (chain && i == 10);
      bus.i_start = go;
      bus.i_key   = go ? nk : ~k;
      @(posedge clk); #1;
    end
    bus.i_start = 1'b0;
    chk("done_count", 128'(dn), 128'(1));
    if (!chain) begin
      chk("valid_end", 128'(bus.o_rk_valid), 128'(0));
      chk("done_end", 128'(bus.o_done), 128'(0));
      chk("key_hold", bus.o_round_key, rk[10]);
    end
  endtask
  task automatic readback(input logic zero);
    for (int i = 0; i <= 11; i++) begin
      bus.i_rd_idx = i == 11 ? 4'd15 : 4'(i);
      @(posedge clk); #1;
      chk("rd_key", bus.o_rd_key, (zero || i == 11) ? 128'(0) : rk[i]);
      chk("nostore_rd", bus0.o_rd_key, 128'(0));
      chk("rd_no_done", 128'(bus.o_done), 128'(0));
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 128'(bus.o_busy), 128'(0));
    chk({tag, "_valid"}, 128'(bus.o_rk_valid), 128'(0));
    chk({tag, "_idx"}, 128'(bus.o_rk_idx), 128'(0));
    chk({tag, "_key"}, bus.o_round_key, 128'(0));
    chk({tag, "_done"}, 128'(bus.o_done), 128'(0));
    chk({tag, "_rd"}, bus.o_rd_key, 128'(0));
  endtask
  initial begin
    rst          = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_key    = '0;
    bus.i_rd_idx = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    start_exp(K1);
    stream(K1, K1H1, K1HA, -1, 1'b0, '0);
    start_exp(K2);
    stream(K2, K2H1, K2HA, -1, 1'b0, '0);
    readback(1'b0);
    start_exp(K1);
    stream(K1, K1H1, K1HA, 5, 1'b1, K2);
    stream(K2, K2H1, K2HA, -1, 1'b0, '0);
    start_exp(K1);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_idx", 128'(bus.o_rk_idx), 128'(6));
    #2 rst = 1'b1;
    #1;
    chk_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("after_reset");
    readback(1'b1);
    start_exp(K1);
    stream(K1, K1H1, K1HA, -1, 1'b0, '0);
    readback(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
